// File: rtl/prio_arbiter_pkg.sv
// Shared types and helpers for the prio_arbiter block: FSM state, clog2, requester limit.
package arb_pkg;

  localparam int unsigned MAX_N_REQ = 32;

  typedef enum logic {
    StIdle,
    StBusy
  } arb_state_e;

  // Elaboration-time ceil(log2(v)); clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface prio_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = clog2(N_REQ)
);

  logic [N_REQ-1:0] req;
  logic             rel;         // release pulse from the current owner
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] gnt_onehot;
  logic             timeout;

  modport master (
    output req,
    output rel,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt_onehot,
    input  timeout
  );

  modport slave (
    input  req,
    input  rel,
    output gnt_valid,
    output gnt_idx,
    output gnt_onehot,
    output timeout
  );

endinterface

// File: rtl/prio_arbiter_find.sv
// Combinational find-first-set over req_i, searching upward from start_i with wrap-around.
module prio_arbiter_find
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    int unsigned pos;
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    pos      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pos = int'(start_i) + i;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      if (!found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(pos);
      end
    end
    if (found_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with hold timeout and a mandatory one-cycle gap between grants.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned IDX_W    = clog2(N_REQ),
  parameter int unsigned MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  prio_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_HOLD == 0) ? 1 : clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;
  logic             tmo_q, tmo_d;

  logic             find_found;
  logic [IDX_W-1:0] find_idx;
  logic [N_REQ-1:0] find_onehot;
  logic [IDX_W-1:0] search_start;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_q, rr_d;
  assign search_start = rr_q;
`else
  assign search_start = '0;
`endif

  prio_arbiter_find #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_find (
    .req_i    (bus.req),
    .start_i  (search_start),
    .found_o  (find_found),
    .idx_o    (find_idx),
    .onehot_o (find_onehot)
  );

  logic owner_req;
  logic hold_expired;
  logic busy_exit;

  assign owner_req    = bus.req[idx_q];
  assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign busy_exit    = bus.rel || !owner_req || hold_expired;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    tmo_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_d     = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        valid_d  = 1'b0;
        idx_d    = '0;
        onehot_d = '0;
        if (find_found) begin
          state_d  = StBusy;
          valid_d  = 1'b1;
          idx_d    = find_idx;
          onehot_d = find_onehot;
          cnt_d    = '0;
`ifdef ARB_ROUND_ROBIN_EN
          rr_d     = (find_idx == IDX_W'(N_REQ - 1)) ? '0 : find_idx + 1'b1;
`endif
        end
      end
      StBusy: begin
        if (busy_exit) begin
          state_d  = StIdle;
          valid_d  = 1'b0;
          idx_d    = '0;
          onehot_d = '0;
          // Release or withdraw in the expiry cycle wins over the timeout.
          tmo_d    = !bus.rel && owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      tmo_q    <= tmo_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign bus.gnt_valid  = valid_q;
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
  assign bus.timeout    = tmo_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter (N_REQ=4, MAX_HOLD=4): directed scenarios then random traffic,
// each cycle compared against an owner/hold-count reference model.
module tb_prio_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic clk;
  logic rst;

  prio_arbiter_if #(.N_REQ(N)) bus ();

  prio_arbiter #(
    .N_REQ    (N),
    .MAX_HOLD (MH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the resource, for how many cycles, and the rotation point.
  int owner = -1;
  int held  = 0;
  int rr    = 0;
  bit tmo   = 1'b0;
  int valid_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] r, input bit rl, input bit rs);
    int start;
    int p;
    if (rs) begin
      owner = -1;
      held  = 0;
      rr    = 0;
      tmo   = 1'b0;
    end else if (owner >= 0) begin
      if (rl || !r[owner] || (MH > 0 && held == MH)) begin
        tmo   = !rl && r[owner];
        owner = -1;
      end else begin
        held++;
        tmo = 1'b0;
      end
    end else begin
      tmo = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      start = rr;
`else
      start = 0;
`endif
      for (int k = 0; k < N; k++) begin
        p = (start + k) % N;
        if (owner < 0 && r[p]) begin
          owner = p;
          held  = 1;
          rr    = (p + 1) % N;
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input bit rl, input bit rs);
    bus.req = r;
    bus.rel = rl;
    rst     = rs;
    @(posedge clk);
    model_step(r, rl, rs);
    #1;
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(owner >= 0));
    chk("gnt_idx", 32'(bus.gnt_idx), (owner >= 0) ? 32'(owner) : 32'd0);
    chk("gnt_onehot", 32'(bus.gnt_onehot), (owner >= 0) ? (32'd1 << owner) : 32'd0);
    chk("timeout", 32'(bus.timeout), 32'(tmo));
    valid_run = bus.gnt_valid ? valid_run + 1 : 0;
  endtask

  initial begin
    int run_at_drop;
    logic [3:0] r;
    bus.req = '0;
    bus.rel = 1'b0;
    rst     = 1'b1;

    // Reset and idle.
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 1);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);

    // Simultaneous requests, then release by the owner.
    step(4'b0110, 0, 0);
`ifndef ARB_ROUND_ROBIN_EN
    chk("first_winner", 32'(bus.gnt_idx), 32'd1);
`endif
    step(4'b0110, 0, 0);
    step(4'b0110, 1, 0);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);

    // Hold timeout on requester 3, then regrant after the gap.
    run_at_drop = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.gnt_valid) run_at_drop = valid_run;
      step(4'b1000, 0, 0);
      if (bus.timeout) chk("hold_len", 32'(run_at_drop), 32'(MH));
    end
    step(4'b0000, 0, 0);
    step(4'b0000, 0, 0);

    // Owner withdraws while another line waits.
    step(4'b0101, 0, 0);
    step(4'b0101, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);

    // Reset mid-grant.
    step(4'b0100, 0, 1);
    step(4'b0000, 0, 0);

    // Release in the expiry cycle suppresses the timeout.
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 0, 0);
    step(4'b1000, 1, 0);
    step(4'b0000, 0, 0);

    // Non-owner lines toggling while busy.
    step(4'b0010, 0, 0);
    step(4'b1011, 0, 0);
    step(4'b0110, 0, 0);
    step(4'b0000, 0, 0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      step(r, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
